keyboard_rx: RTL
================

# keyboard_rx

UART receiver with a small show-ahead FIFO that feeds the CPU's `KEYBOARD` instruction. It deserialises 8N1 frames from the board's `uart_rx` pin at the same bit period (`WAIT` clocks) as the mother_board transmitter, buffers received bytes, and presents the oldest byte to the CPU. It also reports overflow, framing error and an interrupt request.

## Interface
Parameters:
- `WAIT`, default 868: clocks per bit (CLOCK_HZ/baud); must be ≥ 4.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high; all state is cleared on the clock edge where it is high.
- `uart_rx`, in, 1: asynchronous serial input; idles high.
- `rd_en`, in, 1: CPU pop request (`KEYBOARD` executed).
- `rd_data`, out, 8: oldest buffered byte; show-ahead.
- `rd_valid`, out, 1: FIFO not empty.
- `level`, out, $clog2(DEPTH)+1: number of buffered bytes.
- `overflow`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `frame_err`, out, 1: sticky; a stop bit was sampled low.
- `clr_err`, in, 1: clears `overflow` and `frame_err`.
- `irq`, out, 1: equals `rd_valid | overflow | frame_err`.

## Operation
- **Input synchroniser:** `uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- **Bit counter:** `cnt` counts 0..WAIT-1. `bit_idx` counts 0..7.
- **IDLE:** on `rxs==0`, go to START with `cnt=0`.
- **START:** when `cnt==WAIT/2-1`, sample `rxs`.
  - 1: false start; return to IDLE.
  - 0: go to DATA with `cnt=0`, `bit_idx=0`.
- **DATA:** when `cnt==WAIT-1`, shift `rxs` into bit `bit_idx` (LSB first).
  - After bit 7, go to STOP.
- **STOP:** when `cnt==WAIT-1`, sample `rxs`.
  - 1: push the byte and go to IDLE.
  - 0: set `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** return to IDLE once `rxs==1`. Guarantees a break condition is not read as back-to-back start bits.
- **FIFO:** read/write pointers of $clog2(DEPTH)+1 bits. Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
- **Push when full:** byte dropped and `overflow` set, unless a pop occurs on the same edge. Simultaneous pop and push on a full FIFO succeed; `level` stays at DEPTH.
- **`rd_en` while empty:** ignored; no pointer change.
- **Pop and push on the same edge with `level==0`:** the push is kept and the pop ignored; result is `level=1`.
- **Error flag priority:** `clr_err` clears both flags. A set event on the same edge wins over the clear.
- **`rd_data` when empty:** don't-care; the bench must not check it.
- **Reset mid-frame:** the partial byte is discarded. FSM goes to IDLE, FIFO empties, flags clear. The next frame is received normally once `uart_rx` idles high.

## Timing
- **Reset values:** `rd_valid=0`, `level=0`, `overflow=0`, `frame_err=0`, `irq=0`. `rd_data` reads 8'h00 (storage cleared on reset).
- **Start detect:** let cycle T0 be the first edge where `rxs==0` in IDLE. This is 2–3 clocks after the falling edge on `uart_rx`.
- **Sample points:** start bit at T0+WAIT/2. Data bit k at T0+WAIT/2+(k+1)·WAIT. Stop bit at T0+WAIT/2+9·WAIT.
- **Push latency:** the push is registered on the stop-sample edge. `rd_valid`, `level` and `rd_data` update on the following cycle.
- **Pop:** on an edge with `rd_en & rd_valid`, the read pointer advances. New `rd_data` and `level` are visible the next cycle.
- **Back-to-back frames:** a start bit arriving immediately after a stop bit is captured. This allows ≥ 0 idle bits between frames.
- **`irq`:** combinational from registered flags; no extra latency.

## Test plan
All scenarios use `WAIT=16`, `DEPTH=4`, and a bench transmitter driving ideal 8N1 frames.

- **Single byte:** send 8'hA5, `rd_en=0`. Then `rd_valid=1`, `rd_data=8'hA5`, `level=1`, `irq=1`, within T0+152±3 cycles. Pulse `rd_en` once: `rd_valid=0`, `level=0`, `irq=0`.
- **Ordering and overflow:** send 8'h01..8'h05 back-to-back with no reads. Expect `level=4`, `overflow=1`. Four pops return 01, 02, 03, 04; then `rd_valid=0`. Pulse `clr_err`: `overflow=0`.
- **Full with simultaneous pop:** fill the FIFO with 11, 22, 33, 44. Assert `rd_en` on exactly the stop-sample edge of 8'h55. Expect `overflow=0`, `level=4`, pop sequence 22, 33, 44, 55.
- **False start and framing error:** a 4-clock low glitch on `uart_rx` produces no push and no flags. A frame 8'h3C with a low stop bit, held low for 40 clocks, then high, gives `frame_err=1` and `level=0`. The next frame 8'h7E is received correctly.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 8'hF0. Afterwards all outputs are 0. A subsequent 8'h0F is received with `level=1` and `rd_data=8'h0F`.
- **Pop on empty:** `rd_en=1` for 10 cycles while empty gives `level=0` and no underflow. A following byte 8'h80 yields `level=1`.

Source files
------------

// File: rtl/keyboard_rx.sv
// rtl/keyboard_rx.sv - 8N1 UART receiver with show-ahead byte FIFO for the KEYBOARD instruction
module keyboard_rx #(
    parameter int WAIT  = 868,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_rx,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(WAIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          rx_meta, rxs;
    logic          push, stop_bad;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, do_pop, do_push, drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        push      = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d            = '0;
                    shreg_d[bit_idx] = rxs;
                    bit_idx_d        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be taken as a fresh start bit.
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = rd_en & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= shreg;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            if (drop) overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (stop_bad) frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    assign rd_data  = mem[rptr[AW-1:0]];
    assign rd_valid = ~empty;
    assign level    = wptr - rptr;
    assign irq      = rd_valid | overflow | frame_err;
endmodule
